// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory.
// Shares the memory between the CPU load/store path and an auxiliary master.
// Each access takes three cycles: arbitrate and latch (IDLE), strobe (ISSUE),
// then acknowledge (DONE).
module dmem_arbiter #(
  parameter int unsigned AW           = 8,
  parameter int unsigned DW           = 16,
  parameter int unsigned CPU_PRIORITY = 0
) (
  input  logic          i_clk,
  input  logic          i_reset,
  // CPU port
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [DW-1:0] i_cpu_wdata,
  output logic          o_cpu_ack,
  output logic [DW-1:0] o_cpu_rdata,
  output logic          o_cpu_stall,
  // Auxiliary port
  input  logic          i_aux_req,
  input  logic          i_aux_we,
  input  logic [AW-1:0] i_aux_addr,
  input  logic [DW-1:0] i_aux_wdata,
  output logic          o_aux_ack,
  output logic [DW-1:0] o_aux_rdata,
  // Memory port
  output logic          o_mem_re,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  // Status
  output logic          o_busy,
  output logic          o_grant_aux
);

  localparam bit CpuWinsTies = (CPU_PRIORITY != 0);

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic          w_any_req;
  logic          w_pick_aux;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_grant_aux;
  logic          r_last_aux;
  logic          r_cpu_ack;
  logic          r_aux_ack;
  logic [DW-1:0] r_cpu_rdata;
  logic [DW-1:0] r_aux_rdata;

  assign w_any_req = i_cpu_req | i_aux_req;
  // Aux wins when alone, or on a tie in round-robin mode when the CPU was served last.
  assign w_pick_aux = i_aux_req & (~i_cpu_req | (~CpuWinsTies & ~r_last_aux));

  // Next-state logic: a request in IDLE starts a fixed three-cycle access.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_any_req) w_state_next = StIssue;
      StIssue: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // Capture the winner's command when leaving IDLE; it drives the memory until the next win.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_grant_aux <= 1'b0;
    end else if (r_state == StIdle && w_any_req) begin
      r_grant_aux <= w_pick_aux;
      r_we        <= w_pick_aux ? i_aux_we    : i_cpu_we;
      r_addr      <= w_pick_aux ? i_aux_addr  : i_cpu_addr;
      r_wdata     <= w_pick_aux ? i_aux_wdata : i_cpu_wdata;
    end
  end

  // Registered ack pulse and read data, both presented during DONE.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cpu_ack   <= 1'b0;
      r_aux_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_aux_rdata <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_aux_ack <= 1'b0;
      if (r_state == StIssue) begin
        if (r_grant_aux) begin
          r_aux_ack <= 1'b1;
          if (!r_we) r_aux_rdata <= i_mem_rdata;
        end else begin
          r_cpu_ack <= 1'b1;
          if (!r_we) r_cpu_rdata <= i_mem_rdata;
        end
      end
    end
  end

  // Round-robin pointer; resets to "aux served last" so the CPU wins the first tie.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)                r_last_aux <= 1'b1;
    else if (r_state == StDone)  r_last_aux <= r_grant_aux;
  end

  // Strobes decode straight from state so an asynchronous reset drops them at once.
  assign o_mem_re    = (r_state == StIssue) & ~r_we;
  assign o_mem_we    = (r_state == StIssue) &  r_we;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_busy      = (r_state != StIdle);
  assign o_grant_aux = r_grant_aux;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_aux_ack   = r_aux_ack;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_aux_rdata = r_aux_rdata;
  assign o_cpu_stall = i_cpu_req & ~r_cpu_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, aux_req, aux_we;
  logic [7:0]  cpu_addr, aux_addr;
  logic [15:0] cpu_wdata, aux_wdata;
  // Round-robin instance
  logic        cpu_ack, cpu_stall, aux_ack, mem_re, mem_we, busy, grant_aux;
  logic [15:0] cpu_rdata, aux_rdata, mem_wdata, mem_rdata;
  logic [7:0]  mem_addr;
  // Fixed-priority instance
  logic        p_cpu_ack, p_cpu_stall, p_aux_ack, p_mem_re, p_mem_we, p_busy, p_grant_aux;
  logic [15:0] p_cpu_rdata, p_aux_rdata, p_mem_wdata, p_mem_rdata;
  logic [7:0]  p_mem_addr;

  int checks = 0;
  int errors = 0;

  // Memory models: untouched words return a fixed per-address pattern.
  logic [15:0] mem   [256];
  bit          wr    [256];
  logic [15:0] mem_p [256];
  bit          wr_p  [256];

  function automatic logic [15:0] init_word(input logic [7:0] a);
    if (a == 8'h10) return 16'hBEEF;
    return {a, ~a} ^ 16'h5A5A;
  endfunction

  always @(posedge clk) if (mem_we) begin mem[mem_addr] <= mem_wdata; wr[mem_addr] <= 1'b1; end
  always @(posedge clk) if (p_mem_we) begin mem_p[p_mem_addr] <= p_mem_wdata; wr_p[p_mem_addr] <= 1'b1; end
  assign mem_rdata   = wr[mem_addr]     ? mem[mem_addr]     : init_word(mem_addr);
  assign p_mem_rdata = wr_p[p_mem_addr] ? mem_p[p_mem_addr] : init_word(p_mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter #(.AW(8), .DW(16), .CPU_PRIORITY(0)) u_dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_aux_req(aux_req), .i_aux_we(aux_we), .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
    .o_aux_ack(aux_ack), .o_aux_rdata(aux_rdata),
    .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata), .o_busy(busy), .o_grant_aux(grant_aux)
  );

  dmem_arbiter #(.AW(8), .DW(16), .CPU_PRIORITY(1)) u_dut_pri (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(p_cpu_ack), .o_cpu_rdata(p_cpu_rdata), .o_cpu_stall(p_cpu_stall),
    .i_aux_req(aux_req), .i_aux_we(aux_we), .i_aux_addr(aux_addr), .i_aux_wdata(aux_wdata),
    .o_aux_ack(p_aux_ack), .o_aux_rdata(p_aux_rdata),
    .o_mem_re(p_mem_re), .o_mem_we(p_mem_we), .o_mem_addr(p_mem_addr),
    .o_mem_wdata(p_mem_wdata), .i_mem_rdata(p_mem_rdata), .o_busy(p_busy),
    .o_grant_aux(p_grant_aux)
  );

  // Reference model (round-robin instance): an access started at edge S strobes after S,
  // acks after S+1, and the port may accept a new request at edge S+3.
  logic [15:0] ref_mem [256];
  int          edge_n = 0;
  int          act_start = -10;
  bit          m_owner, m_we, m_last_aux;
  logic [7:0]  m_addr;
  logic [15:0] m_wdata, m_cpu_rdata, m_aux_rdata;
  bit          exp_re, exp_we, exp_busy, exp_cpu_ack, exp_aux_ack;

  task automatic model_reset();
    act_start   = -10;
    m_owner     = 1'b0;
    m_we        = 1'b0;
    m_last_aux  = 1'b1;
    m_addr      = '0;
    m_wdata     = '0;
    m_cpu_rdata = '0;
    m_aux_rdata = '0;
    exp_re = 0; exp_we = 0; exp_busy = 0; exp_cpu_ack = 0; exp_aux_ack = 0;
  endtask

  // Advance one clock and update the model's expectations for the cycle that follows.
  task automatic tick();
    int phase;
    if (rst_n) begin
      if (edge_n >= act_start + 3 && (cpu_req || aux_req)) begin
        act_start = edge_n;
        m_owner   = aux_req && (!cpu_req || !m_last_aux);
        m_we      = m_owner ? aux_we    : cpu_we;
        m_addr    = m_owner ? aux_addr  : cpu_addr;
        m_wdata   = m_owner ? aux_wdata : cpu_wdata;
      end else if (edge_n == act_start + 1) begin
        if (m_we)         ref_mem[m_addr] = m_wdata;
        else if (m_owner) m_aux_rdata = ref_mem[m_addr];
        else              m_cpu_rdata = ref_mem[m_addr];
        m_last_aux = m_owner;
      end
    end
    @(posedge clk);
    #1;
    phase       = edge_n - act_start;
    exp_busy    = (phase == 0) || (phase == 1);
    exp_re      = (phase == 0) && !m_we;
    exp_we      = (phase == 0) && m_we;
    exp_cpu_ack = (phase == 1) && !m_owner;
    exp_aux_ack = (phase == 1) && m_owner;
    edge_n++;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    aux_req = 0; aux_we = 0; aux_addr = '0; aux_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({busy, cpu_ack, aux_ack, mem_re, mem_we, grant_aux} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/acks/strobes/grant=%b required 000000",
               {busy, cpu_ack, aux_ack, mem_re, mem_we, grant_aux});
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, aux_rdata} !== 56'h0) begin
      errors++;
      $display("FAIL reset_data: addr/wdata/rdata=%h required 0",
               {mem_addr, mem_wdata, cpu_rdata, aux_rdata});
    end
  endtask

  task automatic test_cpu_load();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    #1;
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL load_stall_T: got %b required 1", cpu_stall); end
    tick();
    checks++;
    if ({mem_re, mem_we, cpu_stall, mem_addr} !== {3'b101, 8'h10}) begin
      errors++;
      $display("FAIL load_issue: re/we/stall/addr=%h required 510", {mem_re, mem_we, cpu_stall, mem_addr});
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'hBEEF || mem_re !== 1'b0 || cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL load_ack: ack=%b rdata=%h re=%b stall=%b required 1 beef 0 0",
               cpu_ack, cpu_rdata, mem_re, cpu_stall);
    end
    cpu_req = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL load_idle: busy=%b ack=%b required 0 0", busy, cpu_ack);
    end
  endtask

  task automatic test_aux_store_cpu_load();
    logic [15:0] aux_before;
    aux_before = m_aux_rdata;
    aux_req = 1; aux_we = 1; aux_addr = 8'h20; aux_wdata = 16'h1234;
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 8'h20 || mem_wdata !== 16'h1234) begin
      errors++;
      $display("FAIL aux_store_issue: we=%b re=%b addr=%h wdata=%h required 1 0 20 1234",
               mem_we, mem_re, mem_addr, mem_wdata);
    end
    aux_req = 0;
    tick();
    checks++;
    if (aux_ack !== 1'b1 || aux_rdata !== aux_before || grant_aux !== 1'b1) begin
      errors++;
      $display("FAIL aux_store_ack: ack=%b rdata=%h grant=%b required 1 %h 1",
               aux_ack, aux_rdata, grant_aux, aux_before);
    end
    tick();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 16'h1234) begin
      errors++; $display("FAIL cpu_reads_store: ack=%b rdata=%h required 1 1234", cpu_ack, cpu_rdata);
    end
    cpu_req = 0;
    tick();
  endtask

  task automatic test_contention_rr();
    int  ack_edge[$];
    bit  ack_who[$];
    bit  want[4];
    want = '{1'b0, 1'b1, 1'b0, 1'b1};
    do_reset();
    cpu_req = 1; cpu_addr = 8'h01; aux_req = 1; aux_addr = 8'h02;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (cpu_ack && aux_ack) begin errors++; $display("FAIL rr_double_ack: cycle %0d both acks high", i); end
      if (cpu_ack) begin ack_edge.push_back(i); ack_who.push_back(1'b0); end
      if (aux_ack) begin ack_edge.push_back(i); ack_who.push_back(1'b1); end
    end
    checks++;
    if (ack_who.size() != 4) begin
      errors++; $display("FAIL rr_ack_count: got %0d required 4", ack_who.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ack_who[k] !== want[k] || ack_edge[k] != 1 + 3 * k) begin
          errors++;
          $display("FAIL rr_order[%0d]: owner=%b cycle=%0d required %b %0d",
                   k, ack_who[k], ack_edge[k], want[k], 1 + 3 * k);
        end
      end
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_contention_priority();
    int  n_cpu = 0;
    int  n_aux = 0;
    int  found = -1;
    do_reset();
    cpu_req = 1; cpu_addr = 8'h03; aux_req = 1; aux_addr = 8'h04;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (p_cpu_ack) n_cpu++;
      if (p_aux_ack) n_aux++;
    end
    checks++;
    if (n_cpu != 4 || n_aux != 0) begin
      errors++; $display("FAIL pri_hold: cpu acks=%0d aux acks=%0d required 4 0", n_cpu, n_aux);
    end
    cpu_req = 0;
    for (int i = 0; i < 6 && found < 0; i++) begin
      tick();
      if (p_aux_ack) found = i;
    end
    checks++;
    if (found != 1) begin
      errors++; $display("FAIL pri_aux_after_drop: aux ack at %0d required 1", found);
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h33; cpu_wdata = 16'hA5A5;
    tick();
    checks++;
    if (mem_we !== 1'b1) begin errors++; $display("FAIL mid_rst_pre: mem_we=%b required 1", mem_we); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_drop: we=%b busy=%b ack=%b required 0 0 0", mem_we, busy, cpu_ack);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_noack: ack=%b required 0", cpu_ack); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h33) begin
      errors++; $display("FAIL mid_rst_reissue: we=%b addr=%h required 1 33", mem_we, mem_addr);
    end
    tick();
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL mid_rst_ack: ack=%b required 1", cpu_ack); end
    idle_inputs();
    tick();
    checks++;
    if (mem[8'h33] !== 16'hA5A5) begin
      errors++; $display("FAIL mid_rst_stored: mem=%h required a5a5", mem[8'h33]);
    end
  endtask

  task automatic test_withdraw();
    aux_req = 1; aux_we = 0; aux_addr = 8'h05;
    tick();
    aux_req = 0;
    tick();
    checks++;
    if (aux_ack !== 1'b1 || aux_rdata !== init_word(8'h05)) begin
      errors++;
      $display("FAIL withdraw_ack: ack=%b rdata=%h required 1 %h", aux_ack, aux_rdata, init_word(8'h05));
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || mem_re !== 1'b0 || aux_ack !== 1'b0) begin
      errors++; $display("FAIL withdraw_idle: busy=%b re=%b ack=%b required 0 0 0", busy, mem_re, aux_ack);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick();
      checks++;
      if ({mem_re, mem_we, busy, cpu_ack, aux_ack} !== {exp_re, exp_we, exp_busy, exp_cpu_ack, exp_aux_ack}) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: re/we/busy/cack/aack=%b required %b", i,
                 {mem_re, mem_we, busy, cpu_ack, aux_ack},
                 {exp_re, exp_we, exp_busy, exp_cpu_ack, exp_aux_ack});
      end
      checks++;
      if (grant_aux !== m_owner || mem_addr !== m_addr || mem_wdata !== m_wdata) begin
        errors++;
        $display("FAIL rand_cmd[%0d]: grant=%b addr=%h wdata=%h required %b %h %h", i,
                 grant_aux, mem_addr, mem_wdata, m_owner, m_addr, m_wdata);
      end
      checks++;
      if (cpu_rdata !== m_cpu_rdata || aux_rdata !== m_aux_rdata) begin
        errors++;
        $display("FAIL rand_rdata[%0d]: cpu=%h aux=%h required %h %h", i,
                 cpu_rdata, aux_rdata, m_cpu_rdata, m_aux_rdata);
      end
      cpu_req   = ($urandom_range(0, 9) < 7);
      cpu_we    = $urandom_range(0, 1);
      cpu_addr  = 8'($urandom_range(0, 15));
      cpu_wdata = 16'($urandom);
      aux_req   = ($urandom_range(0, 9) < 6);
      aux_we    = $urandom_range(0, 1);
      aux_addr  = 8'($urandom_range(0, 15));
      aux_wdata = 16'($urandom);
      #1;
      checks++;
      if (cpu_stall !== (cpu_req && !exp_cpu_ack)) begin
        errors++;
        $display("FAIL rand_stall[%0d]: got %b required %b", i, cpu_stall, cpu_req && !exp_cpu_ack);
      end
    end
    idle_inputs();
    repeat (3) tick();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ref_mem[a] = init_word(8'(a));
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_cpu_load();
    test_aux_store_cpu_load();
    test_contention_rr();
    test_contention_priority();
    test_reset_mid_access();
    test_withdraw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
